// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings and control constants for the multi-cycle control unit
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_RTYPE    = 4'd2,
    S_RITYPE   = 4'd3,
    S_RTYPEEND = 4'd4,
    S_LW1      = 4'd5,
    S_LW2      = 4'd6,
    S_SW       = 4'd7,
    S_JALR     = 4'd8,
    S_BRANCH   = 4'd9,
    S_BRANCH2  = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SET = 12;
  localparam logic [31:0] ALU_NOP_ALL1 = '1;
  localparam int OP_RTYPE = 0;
  localparam int OP_RI    = 1;
  localparam int OP_RI2   = 2;
  localparam int OP_NOP   = 3;
  localparam int OP_JAL   = 4;
  localparam logic [1:0] PCS_ALU  = 2'd0;
  localparam logic [1:0] PCS_BR   = 2'd1;
  localparam logic [1:0] PCS_TRAP = 2'd2;
  localparam int FN_LW   = 9;
  localparam int FN_SW   = 10;
  localparam int FN_JALR = 11;
  localparam int FN_MAXA = 8;
endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: IR fields, memory handshake and datapath control bundle
interface mc_control_fsm_if #(parameter int OPW = 3, FNW = 4, ALUOPW = 4, CNTW = 16);
  logic [OPW-1:0] opcode;
  logic [FNW-1:0] funct;
  logic mem_ready;
  logic MemReq, MemR, MemW, IoD, IRWrite, PCWrite;
  logic [1:0] PCSrc;
  logic RegWrite, Mem2Reg;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic [ALUOPW-1:0] ALUOp;
  logic Branch;
  logic [1:0] BranchType;
  logic keepALUOut, illegal, retire;
  logic [CNTW-1:0] retired_cnt;
  logic [3:0] state;
  modport master (
    input opcode, funct, mem_ready,
    output MemReq, MemR, MemW, IoD, IRWrite, PCWrite, PCSrc, RegWrite, Mem2Reg,
    ALUSrcA, ALUSrcB, ALUOp, Branch, BranchType, keepALUOut, illegal, retire, retired_cnt, state
  );
  modport slave (
    output opcode, funct, mem_ready,
    input MemReq, MemR, MemW, IoD, IRWrite, PCWrite, PCSrc, RegWrite, Mem2Reg,
    ALUSrcA, ALUSrcB, ALUOp, Branch, BranchType, keepALUOut, illegal, retire, retired_cnt, state
  );
endinterface

// File: rtl/mc_aluop_decode.sv
// mc_aluop_decode: funct to ALU operation map plus out-of-range funct flag
module mc_aluop_decode
  import mc_ctrl_pkg::*;
#(parameter int FNW = 4, ALUOPW = 4) (
  input  logic [FNW-1:0]    funct,
  output logic [ALUOPW-1:0] aluop,
  output logic              bad
);
  always_comb begin
    bad = funct >= FNW'(FN_LW);
    aluop = funct <= FNW'(FN_MAXA) ? ALUOPW'(funct) :
            (funct == FNW'(FN_LW) || funct == FNW'(FN_SW)) ? ALUOPW'(ALU_ADD) :
            funct == FNW'(ALU_SET) ? ALUOPW'(ALU_SET) : ALUOPW'(ALU_NOP_ALL1);
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore control FSM with memory handshake, trap state and retire counter
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(parameter int OPW = 3, FNW = 4, ALUOPW = 4, CNTW = 16, parameter bit TRAP_EN = 1) (
  input logic CLK,
  input logic Reset,
  mc_control_fsm_if.master bus
);
  state_t st;
  logic [ALUOPW-1:0] aop;
  logic bad_fn;
  mc_aluop_decode #(.FNW(FNW), .ALUOPW(ALUOPW)) u_aop (.funct(bus.funct), .aluop(aop), .bad(bad_fn));
  assign bus.state = st;
  always_comb begin
    bus.MemReq = 1'b0;
    bus.MemR = 1'b0;
    bus.MemW = 1'b0;
    bus.IoD = 1'b0;
    bus.IRWrite = 1'b0;
    bus.PCWrite = 1'b0;
    bus.PCSrc = PCS_ALU;
    bus.RegWrite = 1'b0;
    bus.Mem2Reg = 1'b0;
    bus.ALUSrcA = 2'd0;
    bus.ALUSrcB = 2'd0;
    bus.ALUOp = ALUOPW'(ALU_NOP_ALL1);
    bus.Branch = 1'b0;
    bus.BranchType = 2'd0;
    bus.keepALUOut = 1'b0;
    bus.illegal = 1'b0;
    bus.retire = 1'b0;
    case (st)
      S_FETCH: begin
        bus.MemReq = 1'b1;
        bus.MemR = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.ALUOp = ALUOPW'(ALU_ADD);
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.keepALUOut = 1'b1;
        bus.retire = bus.opcode == OPW'(OP_NOP) || (bus.opcode > OPW'(OP_JAL) && !TRAP_EN);
      end
      S_RTYPE: begin
        bus.ALUSrcA = 2'd2;
        bus.ALUOp = aop;
      end
      S_RITYPE: begin
        bus.ALUSrcA = 2'd2;
        bus.ALUSrcB = 2'd2;
        bus.ALUOp = aop;
        bus.Branch = 1'b1;
      end
      S_RTYPEEND: begin
        bus.RegWrite = 1'b1;
        bus.retire = 1'b1;
      end
      S_LW1: begin
        bus.MemReq = 1'b1;
        bus.MemR = 1'b1;
        bus.IoD = 1'b1;
      end
      S_LW2: begin
        bus.RegWrite = 1'b1;
        bus.Mem2Reg = 1'b1;
        bus.retire = 1'b1;
      end
      S_SW: begin
        bus.MemReq = 1'b1;
        bus.IoD = 1'b1;
        bus.MemW = bus.mem_ready;
        bus.retire = bus.mem_ready;
      end
      S_JALR: begin
        bus.ALUSrcA = 2'd2;
        bus.ALUSrcB = 2'd2;
        bus.ALUOp = ALUOPW'(ALU_ADD);
        bus.PCWrite = 1'b1;
        bus.RegWrite = 1'b1;
        bus.keepALUOut = 1'b1;
        bus.retire = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcB = 2'd2;
        bus.ALUOp = ALUOPW'(ALU_ADD);
        bus.Branch = 1'b1;
        bus.BranchType = bus.funct[1:0];
      end
      S_BRANCH2: begin
        bus.ALUSrcA = 2'd2;
        bus.ALUOp = ALUOPW'(ALU_SUB);
        bus.Branch = 1'b1;
        bus.BranchType = bus.funct[1:0];
        bus.PCSrc = PCS_BR;
        bus.PCWrite = 1'b1;
        bus.retire = 1'b1;
      end
      S_JAL: begin
        bus.ALUSrcB = 2'd2;
        bus.ALUOp = ALUOPW'(ALU_SET);
        bus.RegWrite = 1'b1;
        bus.PCWrite = 1'b1;
        bus.retire = 1'b1;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
        bus.PCSrc = PCS_TRAP;
        bus.PCWrite = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      st <= S_FETCH;
      bus.retired_cnt <= '0;
    end else begin
      bus.retired_cnt <= bus.retired_cnt + CNTW'(bus.retire);
      case (st)
        S_FETCH: st <= bus.mem_ready ? S_DECODE : S_FETCH;
        // funct 11xx under opcode 001 selects the branch family
        S_DECODE: st <= bus.opcode == OPW'(OP_RTYPE) ? S_RTYPE :
                        bus.opcode == OPW'(OP_RI) ? (bus.funct == FNW'(FN_JALR) ? S_JALR :
                                                     (bus.funct >> 2) == FNW'(3) ? S_BRANCH : S_RITYPE) :
                        bus.opcode == OPW'(OP_RI2) ? S_RITYPE :
                        bus.opcode == OPW'(OP_NOP) ? S_FETCH :
                        bus.opcode == OPW'(OP_JAL) ? S_JAL :
                        TRAP_EN ? S_TRAP : S_FETCH;
        S_RTYPE: st <= bad_fn && TRAP_EN ? S_TRAP : S_RTYPEEND;
        S_RITYPE: st <= bus.funct == FNW'(FN_LW) ? S_LW1 : bus.funct == FNW'(FN_SW) ? S_SW : S_RTYPEEND;
        S_LW1: st <= bus.mem_ready ? S_LW2 : S_LW1;
        S_SW: st <= bus.mem_ready ? S_FETCH : S_SW;
        S_BRANCH: st <= S_BRANCH2;
        default: st <= S_FETCH;
      endcase
    end
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multi-cycle control unit for the 16-bit multi-cycle processor. It is the successor of the fixed-latency control FSM. New behaviour over that FSM:
- memory ready/request handshake, so fetch, load and store stall until memory responds
- illegal-opcode trap state
- retired-instruction counter
It drives the datapath muxes, register file, memory and PC from a Moore state machine.

Parameters:
OPW, 3, opcode width (instruction field feeding DECODE).
FNW, 4, funct width; must be >=4.
ALUOPW, 4, ALU operation code width.
CNTW, 16, retired-instruction counter width.
TRAP_EN, 1, 1 = illegal encodings go to TRAP; 0 = illegal encodings are treated as NOP (return to FETCH).

Ports:
CLK  in  1  clock; all state changes on rising edge.
Reset  in  1  synchronous, active-high reset.
opcode  in  OPW  opcode field from IR.
funct  in  FNW  funct field from IR.
mem_ready  in  1  memory completes current access this cycle.
MemReq  out  1  memory access requested (FETCH, LW1, SW).
MemR  out  1  read.
MemW  out  1  write.
IoD  out  1  0 = PC address, 1 = ALUOut address.
IRWrite  out  1  load IR.
PCWrite  out  1  PC enable.
PCSrc  out  2  0 = ALU result, 1 = branch target/ALUOut, 2 = trap vector.
RegWrite  out  1  register file write.
Mem2Reg  out  1  1 = MDR to register file.
ALUSrcA  out  2  ALU A mux select.
ALUSrcB  out  2  ALU B mux select.
ALUOp  out  ALUOPW  ALU operation.
Branch  out  1  branch qualifier.
BranchType  out  2  = funct[1:0] in BRANCH/BRANCH2, else 0.
keepALUOut  out  1  hold ALUOut register.
illegal  out  1  high in TRAP.
retire  out  1  one-cycle pulse when an instruction completes.
retired_cnt  out  CNTW  count of retire pulses.
state  out  4  current state encoding, for debug.

Behaviour:
State register and next-state logic:
- Reset high at a CLK edge: state<=FETCH, retired_cnt<=0. Applies mid-operation too; any pending stall is abandoned and no write strobe is asserted in the following cycle beyond those of FETCH.
- Outputs are a pure decode of the registered state plus mem_ready (Moore, except the handshake qualifiers below).
- Default for every output is 0, except ALUOp default = all ones. The cycle after reset shows FETCH values.

State encodings and transitions:
- FETCH=0: MemReq=MemR=1, IoD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD(0), PCSrc=0. IRWrite and PCWrite = mem_ready. Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE=1: keepALUOut=1. Next state by opcode:
  - 000 -> RTYPE.
  - 001: funct 1011 -> JALR; 1100..1111 -> BRANCH; others -> RITYPE.
  - 010 -> RITYPE.
  - 011 -> FETCH (NOP), retire=1.
  - 100 -> JAL.
  - all other opcodes -> TRAP if TRAP_EN, else FETCH with retire=1.
- RTYPE=2: ALUSrcA=2, ALUSrcB=0, ALUOp=map(funct). Next state RTYPEEND, or TRAP if funct>=1001 and TRAP_EN.
- RITYPE=3: ALUSrcA=2, ALUSrcB=2, ALUOp=map(funct), Branch=1. funct 1001 -> LW1; 1010 -> SW; else RTYPEEND.
- RTYPEEND=4: RegWrite=1, Mem2Reg=0, retire=1. Next FETCH.
- LW1=5: MemReq=MemR=1, IoD=1. Hold while !mem_ready; LW2 on mem_ready.
- LW2=6: RegWrite=1, Mem2Reg=1, retire=1. Next FETCH.
- SW=7: MemReq=1, IoD=1, MemW=mem_ready (single write strobe, no repeat on stall). FETCH on mem_ready with retire=1.
- JALR=8: ALUSrcA=2, ALUSrcB=2, ALUOp=ADD, PCWrite=1, RegWrite=1, keepALUOut=1, retire=1. Next FETCH.
- BRANCH=9: ALUSrcA=0, ALUSrcB=2, ALUOp=ADD, Branch=1, BranchType=funct[1:0]. Next BRANCH2.
- BRANCH2=10: ALUSrcA=2, ALUSrcB=0, ALUOp=SUB(1), Branch=1, BranchType=funct[1:0], PCSrc=1, PCWrite=1, retire=1. Next FETCH.
- JAL=11: ALUSrcB=2, ALUOp=SET(1100), RegWrite=1, PCWrite=1, retire=1. Next FETCH.
- TRAP=12: illegal=1, PCSrc=2, PCWrite=1, no RegWrite, retire=0. Next FETCH.
- Encodings 13..15: all outputs default; next FETCH.

ALUOp map (funct -> ALUOp, zero-extended to ALUOPW):
- 0000..1000 -> funct.
- 1001, 1010 -> ADD.
- 1100 -> 1100.
- others -> all ones.

Counter:
- retired_cnt increments on each retire and wraps modulo 2^CNTW, with no saturation.
- Reset and retire in the same cycle: Reset wins, counter = 0.

Decomposition:
- Package mc_ctrl_pkg: state encodings, ALUOp constants (ADD, SUB, SET, NOP_ALL1), opcode constants, PCSrc encodings, funct codes for LW/SW/JALR.
- One sub-module: mc_aluop_decode (combinational funct -> ALUOp map plus illegal-funct flag). FSM and counter stay in the top.

Test Plan:
1. Reset=1 for 2 cycles, then opcode=000, funct=0001, mem_ready=1 -> state 0,1,2,4,0. ALUOp=0001 in RTYPE, RegWrite=1 in state 4, retired_cnt=1.
2. FETCH with mem_ready low 3 cycles -> state stays 0 for 3 cycles with IRWrite=PCWrite=0. On cycle 4, mem_ready=1 gives IRWrite=PCWrite=1 exactly once.
3. Load (opcode=010, funct=1001) with mem_ready low 2 cycles in LW1 -> states 0,1,3,5,5,5,6,0. Mem2Reg=RegWrite=1 only in state 6.
4. Store (opcode=001, funct=1010) -> MemW pulses only in the cycle mem_ready=1. Branch (funct=1110) -> states 9,10 with BranchType=10 and PCSrc=1.
5. opcode=111 with TRAP_EN=1 -> DECODE then state 12: illegal=1, PCSrc=2, PCWrite=1, retire=0. With TRAP_EN=0 -> DECODE to FETCH with retire=1.
6. Reset asserted while in LW1 stall -> next cycle state=0, retired_cnt=0. With CNTW=4 and 16 NOPs, retired_cnt wraps 15->0.
